// File: rtl/dm_wbuf.sv
// Posted-write buffer between the core data port and a handshaked data memory.
// Optional macro DM_WBUF_FWD_EN: forward the youngest matching buffered store to load hits.
module dm_wbuf #(
    parameter int DEPTH = 4,
    parameter int AW    = 10,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    input  logic          cpu_we,
    input  logic          cpu_re,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_stall,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          wbuf_empty
);

    // state  | meaning
    // IDLE   | no memory request outstanding
    // WRITE  | head entry presented to memory, waiting for mem_ready
    // READ   | load miss presented to memory, waiting for mem_ready
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_fifo_addr [DEPTH];
    logic [DW-1:0] r_fifo_data [DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count, w_count_nxt;
    logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic          r_mem_we, w_mem_we_nxt;
    logic          r_mem_re, w_mem_re_nxt;
    logic          r_wbuf_empty;

    logic          w_full, w_push, w_pop, w_load, w_hit, w_miss, w_read_done;
    logic [PW-1:0] w_idx, w_next_head;
`ifdef DM_WBUF_FWD_EN
    logic [DW-1:0] w_fwd_data;
`endif

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_push      = rst && cpu_we && !w_full;
    assign w_pop       = (r_state == S_WRITE) && mem_ready;
    assign w_load      = rst && cpu_re && !cpu_we;
    assign w_miss      = w_load && !w_hit;
    assign w_read_done = (r_state == S_READ) && mem_ready;
    assign w_next_head = r_rptr + PW'(1);
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    // Scan oldest to youngest so the last match wins; the entry being popped still counts.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
`ifdef DM_WBUF_FWD_EN
        w_fwd_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rptr + PW'(i);
            if ((CW'(i) < r_count) && (r_fifo_addr[w_idx] == cpu_addr)) begin
                w_hit = 1'b1;
`ifdef DM_WBUF_FWD_EN
                w_fwd_data = r_fifo_data[w_idx];
`endif
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_we_nxt    = r_mem_we;
        w_mem_re_nxt    = r_mem_re;
        case (r_state)
            S_IDLE: begin
                if (w_miss) begin
                    w_state_nxt    = S_READ;
                    w_mem_re_nxt   = 1'b1;
                    w_mem_addr_nxt = cpu_addr;
                end else if (r_count != '0) begin
                    w_state_nxt     = S_WRITE;
                    w_mem_we_nxt    = 1'b1;
                    w_mem_addr_nxt  = r_fifo_addr[r_rptr];
                    w_mem_wdata_nxt = r_fifo_data[r_rptr];
                end
            end
            S_WRITE: begin
                if (mem_ready) begin
                    if (w_miss) begin
                        w_state_nxt    = S_READ;
                        w_mem_we_nxt   = 1'b0;
                        w_mem_re_nxt   = 1'b1;
                        w_mem_addr_nxt = cpu_addr;
                    end else if (r_count > CW'(1)) begin
                        w_mem_addr_nxt  = r_fifo_addr[w_next_head];
                        w_mem_wdata_nxt = r_fifo_data[w_next_head];
                    end else if (w_push) begin
                        // Store landing in the emptying buffer goes straight out.
                        w_mem_addr_nxt  = cpu_addr;
                        w_mem_wdata_nxt = cpu_din;
                    end else begin
                        w_state_nxt  = S_IDLE;
                        w_mem_we_nxt = 1'b0;
                    end
                end
            end
            S_READ: begin
                if (mem_ready) begin
                    w_state_nxt  = S_IDLE;
                    w_mem_re_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_mem_we_nxt = 1'b0;
                w_mem_re_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
            r_wbuf_empty <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_re     <= w_mem_re_nxt;
            r_wbuf_empty <= (w_count_nxt == '0) && !w_mem_we_nxt;
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= cpu_addr;
            r_fifo_data[r_wptr] <= cpu_din;
        end
    end

    always_comb begin
        cpu_stall = 1'b0;
        cpu_dout  = '0;
        if (rst) begin
            if (cpu_we) begin
                cpu_stall = w_full;
            end else if (cpu_re) begin
                if (w_read_done) begin
                    cpu_dout = mem_rdata;
`ifdef DM_WBUF_FWD_EN
                end else if (w_hit) begin
                    cpu_dout = w_fwd_data;
`endif
                end else begin
                    cpu_stall = 1'b1;
                end
            end
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_we     = r_mem_we;
    assign mem_re     = r_mem_re;
    assign wbuf_empty = r_wbuf_empty;

endmodule
